ifu_fetch: RTL and testbench

Instruction fetch front end between the instruction SRAM port and the core decode/execute stage.
- Drives the word address and enable into a synchronous SRAM: address is registered at posedge, data returns combinationally the following cycle.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/stall handshake.
- Handles branch redirect by flushing the FIFO and squashing the in-flight read.

---
 rtl/ifu_fetch.sv | 107 ++++++++++
 tb/tb_ifu_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch front end.
// Issues word reads to a synchronous instruction SRAM and buffers the
// returned words with their PCs in a small FIFO. The FIFO head is presented
// to decode through a valid/stall handshake. A branch redirect flushes the
// FIFO and squashes the read that is still in flight.
module ifu_fetch #(
  parameter int              PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0,
  parameter int              DEPTH  = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [PC_W-1:0] ins_a,
  output logic            ins_e,
  input  logic [31:0]     ins,
  input  logic            stall,
  input  logic            branch,
  input  logic [PC_W-1:0] branch_pc,
  output logic            ifu_vld,
  output logic [PC_W-1:0] ifu_pc,
  output logic [31:0]     ifu_ins
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [PC_W-1:0] WORD_MASK = ~PC_W'(3);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [PC_W-1:0] fifo_pc  [DEPTH];
  logic [31:0]     fifo_ins [DEPTH];

  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;
  logic [IW-1:0]   wr_slot;

  // Entry 0 is always the head, so the decode outputs come straight from registers.
  assign ins_a   = pc & WORD_MASK;
  assign ifu_vld = (count != '0);
  assign ifu_pc  = fifo_pc[0];
  assign ifu_ins = fifo_ins[0];

  // Handshake decode: a read is only issued if its result is guaranteed a FIFO slot.
  always_comb begin
    pop       = ifu_vld & ~stall & ~branch;
    push      = inflight & ~branch;
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    ins_e     = rstn & ~branch & (occupancy < (CW + 1)'(DEPTH));
    wr_slot   = IW'(count - {{(CW - 1){1'b0}}, pop});
  end

  // Fetch PC, in-flight tracking and occupancy; a branch overrides everything else.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RST_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
    end else if (branch) begin
      pc       <= branch_pc & WORD_MASK;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (ins_e) begin
        pc          <= pc + PC_W'(4);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Shift-style FIFO storage; the head keeps its last value once the FIFO drains.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]  <= '0;
        fifo_ins[i] <= '0;
      end
    end else if (!branch) begin
      if (pop && (count > CW'(1))) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_pc[i]  <= fifo_pc[i+1];
          fifo_ins[i] <= fifo_ins[i+1];
        end
      end
      if (push) begin
        fifo_pc[wr_slot]  <= inflight_pc;
        fifo_ins[wr_slot] <= ins;
      end
    end
  end

  // The issue rule must make a push into a full FIFO impossible.
  overflow_chk : assert property (@(posedge clk) disable iff (!rstn)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: scoreboard of expected {pc, ins} pairs
// compared whenever decode sees a valid head, plus cycle-exact handshake checks.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, branch;
  logic [15:0] branch_pc;
  logic [15:0] ins_a, ifu_pc;
  logic        ins_e, ifu_vld;
  logic [31:0] ins, ifu_ins;

  logic        stall2, branch2;
  logic [15:0] branch_pc2;
  logic [15:0] ins_a2, ifu_pc2;
  logic        ins_e2, ifu_vld2;
  logic [31:0] ins2, ifu_ins2;

  logic [15:0] sram_addr, sram_addr2;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_q2[$];

  ifu_fetch #(.PC_W(16), .RST_PC(16'h0000), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .ins_a(ins_a), .ins_e(ins_e), .ins(ins),
    .stall(stall), .branch(branch), .branch_pc(branch_pc),
    .ifu_vld(ifu_vld), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins)
  );

  ifu_fetch #(.PC_W(16), .RST_PC(16'hFFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .ins_a(ins_a2), .ins_e(ins_e2), .ins(ins2),
    .stall(stall2), .branch(branch2), .branch_pc(branch_pc2),
    .ifu_vld(ifu_vld2), .ifu_pc(ifu_pc2), .ifu_ins(ifu_ins2)
  );

  always #5 clk = ~clk;

  // SRAM contents: word i holds 0xA000_0000 + i
  function automatic logic [31:0] wordAt(input logic [15:0] a);
    return 32'hA000_0000 + {18'b0, a[15:2]};
  endfunction

  // Synchronous SRAM models: address latched on an enabled edge
  always @(posedge clk) begin
    if (ins_e)  sram_addr  <= ins_a;
    if (ins_e2) sram_addr2 <= ins_a2;
  end
  assign ins  = wordAt(sram_addr);
  assign ins2 = wordAt(sram_addr2);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [15:0] bpc);
    stall     = s;
    branch    = b;
    branch_pc = bpc;
  endtask

  task automatic fillExpected(input int which, input logic [15:0] start, input int n);
    logic [15:0] p;
    p = start;
    if (which == 1) exp_q.delete();
    else            exp_q2.delete();
    for (int i = 0; i < n; i++) begin
      if (which == 1) exp_q.push_back('{pc: p, ins: wordAt(p)});
      else            exp_q2.push_back('{pc: p, ins: wordAt(p)});
      p = p + 16'd4;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the main instance: compare the head, pop when consumed
  always @(negedge clk) begin
    if (rstn && !branch && ifu_vld) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_underrun", 32'(exp_q.size()), 32'd1);
      end else begin
        checkOutput("sb_pc", 32'(ifu_pc), 32'(exp_q[0].pc));
        checkOutput("sb_ins", ifu_ins, exp_q[0].ins);
        if (!stall) void'(exp_q.pop_front());
      end
    end
  end

  // Scoreboard for the wrap-around instance (never stalled or redirected)
  always @(negedge clk) begin
    if (rstn && ifu_vld2) begin
      if (exp_q2.size() == 0) begin
        checkOutput("sb2_underrun", 32'(exp_q2.size()), 32'd1);
      end else begin
        checkOutput("sb2_pc", 32'(ifu_pc2), 32'(exp_q2[0].pc));
        checkOutput("sb2_ins", ifu_ins2, exp_q2[0].ins);
        void'(exp_q2.pop_front());
      end
    end
  end

  initial begin
    rstn       = 1'b0;
    stall2     = 1'b0;
    branch2    = 1'b0;
    branch_pc2 = 16'h0000;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    fillExpected(1, 16'h0000, 32);
    fillExpected(2, 16'hFFF8, 32);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_vld", 32'(ifu_vld), 32'd0);
    checkOutput("rst_ins_e", 32'(ins_e), 32'd0);
    checkOutput("rst_ifu_pc", 32'(ifu_pc), 32'd0);
    checkOutput("rst_ifu_ins", ifu_ins, 32'd0);
    checkOutput("rst_ins_a", 32'(ins_a), 32'h0000);
    checkOutput("rst_ins_a2", 32'(ins_a2), 32'hFFF8);

    // Reset release: issue in the first cycle, valid two cycles later
    rstn = 1'b1;
    #1;
    checkOutput("start_ins_e", 32'(ins_e), 32'd1);
    stepCycle();
    checkOutput("start_vld_low", 32'(ifu_vld), 32'd0);
    stepCycle();
    checkOutput("start_vld_high", 32'(ifu_vld), 32'd1);
    checkOutput("start_pc", 32'(ifu_pc), 32'h0000);
    stepCycle();
    stepCycle();
    checkOutput("pre_stall_pc", 32'(ifu_pc), 32'h0008);

    // Stall for 6 cycles with 0x0008 at the head
    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("stall_hold_pc", 32'(ifu_pc), 32'h0008);
      if (i >= 1) checkOutput("stall_ins_e", 32'(ins_e), 32'd0);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 16'h0000);
    stepCycle();

    // Branch to 0x0100 while 0x0010 is in flight
    checkOutput("pre_branch_pc", 32'(ifu_pc), 32'h000C);
    applyStimulus(1'b0, 1'b1, 16'h0100);
    fillExpected(1, 16'h0100, 32);
    #1;
    checkOutput("branch_ins_e", 32'(ins_e), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    #1;
    checkOutput("br1_vld_c1", 32'(ifu_vld), 32'd0);
    checkOutput("br1_ins_e", 32'(ins_e), 32'd1);
    checkOutput("br1_ins_a", 32'(ins_a), 32'h0100);
    stepCycle();
    checkOutput("br1_vld_c2", 32'(ifu_vld), 32'd0);
    stepCycle();
    checkOutput("br1_vld_c3", 32'(ifu_vld), 32'd1);
    checkOutput("br1_head", 32'(ifu_pc), 32'h0100);

    // Fill the FIFO under stall, then branch to an unaligned target
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000);
    stepCycle();
    stepCycle();
    checkOutput("full_ins_e", 32'(ins_e), 32'd0);
    checkOutput("full_head", 32'(ifu_pc), 32'h010C);
    applyStimulus(1'b1, 1'b1, 16'h0203);
    fillExpected(1, 16'h0200, 32);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    #1;
    checkOutput("br2_ins_a", 32'(ins_a), 32'h0200);
    checkOutput("br2_ins_e", 32'(ins_e), 32'd1);
    checkOutput("br2_vld_c1", 32'(ifu_vld), 32'd0);
    stepCycle();
    checkOutput("br2_vld_c2", 32'(ifu_vld), 32'd0);
    stepCycle();
    checkOutput("br2_head", 32'(ifu_pc), 32'h0200);
    repeat (3) stepCycle();

    // Asynchronous reset between clock edges
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_vld", 32'(ifu_vld), 32'd0);
    checkOutput("mid_rst_ins_e", 32'(ins_e), 32'd0);
    checkOutput("mid_rst_pc", 32'(ifu_pc), 32'd0);
    checkOutput("mid_rst_ins", ifu_ins, 32'd0);
    checkOutput("mid_rst_ins_a", 32'(ins_a), 32'd0);
    checkOutput("mid_rst_vld2", 32'(ifu_vld2), 32'd0);
    checkOutput("mid_rst_ins_e2", 32'(ins_e2), 32'd0);
    fillExpected(1, 16'h0000, 32);
    fillExpected(2, 16'hFFF8, 32);
    stepCycle();
    rstn = 1'b1;
    #1;
    checkOutput("restart_ins_e", 32'(ins_e), 32'd1);
    checkOutput("restart_ins_e2", 32'(ins_e2), 32'd1);
    stepCycle();
    checkOutput("restart_vld_low", 32'(ifu_vld), 32'd0);
    stepCycle();
    checkOutput("restart_head", 32'(ifu_pc), 32'h0000);
    checkOutput("restart_head2", 32'(ifu_pc2), 32'hFFF8);
    repeat (8) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
